// File: rtl/vga_receiver.sv
// VGA sink: recovers pixel coordinates from negative-polarity hsync/vsync,
// checks line and frame lengths against nominal timing, reports lock/errors.
module vga_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clock,
  input  logic       res,
  input  logic       horizontalSync,
  input  logic       verticalSync,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  output logic [9:0] pixelX,
  output logic [9:0] pixelY,
  output logic       active,
  output logic [3:0] redOut,
  output logic [3:0] greenOut,
  output logic [3:0] blueOut,
  output logic       frameStart,
  output logic       locked,
  output logic [7:0] errorCount
);
  localparam logic [10:0] H_LO   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_HI   = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_LO   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_HI   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [11:0] H_TOT  = 12'(H_TOTAL);
  localparam logic [10:0] V_TOT  = 11'(V_TOTAL);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [10:0] H_MAX  = 11'h7ff;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  // sync inputs and RGB share the same two-stage delay so they stay aligned
  logic [1:0]  hs_sync, vs_sync;
  logic        hs_prev, vs_prev;
  logic [11:0] rgb_d1, rgb_d2;
  logic        hs_fall, vs_fall;

  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      hs_sync <= '0;
      vs_sync <= '0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      rgb_d1  <= '0;
      rgb_d2  <= '0;
    end else begin
      hs_sync <= {hs_sync[0], horizontalSync};
      vs_sync <= {vs_sync[0], verticalSync};
      hs_prev <= hs_sync[1];
      vs_prev <= vs_sync[1];
      rgb_d1  <= {red, green, blue};
      rgb_d2  <= rgb_d1;
    end
  end

  assign hs_fall = hs_prev & ~hs_sync[1];
  assign vs_fall = vs_prev & ~vs_sync[1];

  // h_now/l_now are the coordinates of the sample currently at the sync output
  logic [10:0] h_q, h_now;
  logic [9:0]  l_q, l_now;
  logic        seen_hs, seen_vs, to_flag;
  logic [10:0] measured;
  logic        bad_line, bad_frame, timeout, err_any;

  always_comb begin
    h_now = h_q;
    if (hs_fall)           h_now = '0;
    else if (h_q != H_MAX) h_now = h_q + 11'd1;
    l_now = l_q;
    if (vs_fall)           l_now = '0;
    else if (hs_fall)      l_now = l_q + 10'd1;
  end

  // a hsync coincident with vsync closes the old frame's last line
  assign measured  = {1'b0, l_q} + {10'd0, hs_fall};
  assign bad_line  = hs_fall & seen_hs & (({1'b0, h_q} + 12'd1) != H_TOT);
  assign bad_frame = vs_fall & seen_vs & (measured != V_TOT);
  assign timeout   = (h_now == H_MAX) & ~to_flag;
  assign err_any   = bad_line | bad_frame | timeout;

  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      h_q     <= '0;
      l_q     <= '0;
      seen_hs <= 1'b0;
      seen_vs <= 1'b0;
      to_flag <= 1'b0;
    end else begin
      h_q     <= h_now;
      l_q     <= l_now;
      seen_hs <= seen_hs | hs_fall;
      seen_vs <= seen_vs | vs_fall;
      to_flag <= hs_fall ? 1'b0 : (to_flag | timeout);
    end
  end

  // lock FSM: state register / next state / output
  state_t     state_q, state_d;
  logic [3:0] gf_q, gf_d, gf_inc;
  logic       lock_d;

  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      state_q <= SEARCH;
      gf_q    <= '0;
    end else begin
      state_q <= state_d;
      gf_q    <= gf_d;
    end
  end

  assign gf_inc = gf_q + 4'd1;

  always_comb begin
    state_d = state_q;
    gf_d    = gf_q;
    case (state_q)
      SEARCH: if (vs_fall) begin
        state_d = VERIFY;
        gf_d    = '0;
      end
      VERIFY: begin
        if (err_any) gf_d = '0;
        else if (vs_fall && seen_vs) begin
          gf_d = gf_inc;
          if (gf_inc >= LOCK_N) state_d = LOCKED;
        end
      end
      LOCKED: if (err_any) begin
        state_d = VERIFY;
        gf_d    = '0;
      end
      default: begin
        state_d = SEARCH;
        gf_d    = '0;
      end
    endcase
  end

  always_comb begin
    lock_d = (state_d == LOCKED);
  end

  // output register stage
  logic       act_d;
  logic [9:0] px_d, py_d;
  logic [8:0] err_sum;
  logic [7:0] err_d;

  assign act_d   = (h_now >= H_LO) && (h_now < H_HI) && (l_now >= V_LO) && (l_now < V_HI);
  assign px_d    = h_now[9:0] - H_LO[9:0];
  assign py_d    = l_now - V_LO;
  assign err_sum = {1'b0, errorCount} + {8'd0, bad_line} + {8'd0, bad_frame} + {8'd0, timeout};
  assign err_d   = err_sum[8] ? 8'hff : err_sum[7:0];

  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      pixelX     <= '0;
      pixelY     <= '0;
      active     <= 1'b0;
      redOut     <= '0;
      greenOut   <= '0;
      blueOut    <= '0;
      frameStart <= 1'b0;
      locked     <= 1'b0;
      errorCount <= '0;
    end else begin
      pixelX     <= act_d ? px_d : '0;
      pixelY     <= act_d ? py_d : '0;
      active     <= act_d;
      {redOut, greenOut, blueOut} <= act_d ? rgb_d2 : 12'd0;
      frameStart <= vs_fall;
      locked     <= lock_d;
      errorCount <= err_d;
    end
  end
endmodule

// File: tb/tb_vga_receiver.sv
// Directed bench for vga_receiver using a scaled-down timing (200x12 clocks)
// so several whole frames fit in a short run.
module tb_vga_receiver;
  localparam int HT = 200, HS = 12, HB = 8, HA = 160;
  localparam int VT = 12, VS = 2, VB = 3, VA = 6;

  logic       clock = 1'b0;
  logic       res = 1'b0;
  logic       horizontalSync = 1'b1, verticalSync = 1'b1;
  logic [3:0] red = '0, green = '0, blue = '0;
  logic [9:0] pixelX, pixelY;
  logic       active, frameStart, locked;
  logic [3:0] redOut, greenOut, blueOut;
  logic [7:0] errorCount;

  vga_receiver #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clock(clock), .res(res), .horizontalSync(horizontalSync), .verticalSync(verticalSync),
    .red(red), .green(green), .blue(blue), .pixelX(pixelX), .pixelY(pixelY),
    .active(active), .redOut(redOut), .greenOut(greenOut), .blueOut(blueOut),
    .frameStart(frameStart), .locked(locked), .errorCount(errorCount)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int gh = 0, gv = 0, hlen = HT;

  typedef struct {
    int         v, h;
    logic [9:0] px, py;
    logic       act;
    logic [11:0] rgb;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // one pixel of the reference generator, driven on the falling edge
  task automatic tick();
    int x, y;
    logic act;
    @(negedge clock);
    act = (gh >= HS+HB) && (gh < HS+HB+HA) && (gv >= VS+VB) && (gv < VS+VB+VA);
    x = gh - (HS+HB);
    y = gv - (VS+VB);
    horizontalSync = (gh >= HS);
    verticalSync   = (gv >= VS);
    red   = act ? x[3:0] : 4'h0;
    green = act ? y[3:0] : 4'h0;
    blue  = act ? 4'hA : 4'h0;
    gh++;
    if (gh >= hlen) begin
      gh = 0;
      hlen = HT;
      gv = (gv + 1) % VT;
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      horizontalSync = 1'b1; verticalSync = 1'b1;
      red = '0; green = '0; blue = '0;
    end
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 20; j++) begin
        @(negedge clock);
        horizontalSync = (j >= 4); verticalSync = 1'b1;
        red = '0; green = '0; blue = '0;
      end
  endtask

  task automatic run_to(input int v, input int h);
    int c = 0;
    while (!(gv == v && gh == h)) begin
      tick();
      c++;
      if (c > 6000) begin
        checks++; failures++;
        $display("FAIL run_to: generator never reached line %0d col %0d", v, h);
        break;
      end
    end
  endtask

  task automatic wait_fs(output logic lk);
    int c = 0;
    lk = 1'b0;
    do begin
      tick();
      c++;
    end while (!frameStart && c < 3000);
    if (!frameStart) begin
      checks++; failures++;
      $display("FAIL wait_fs: no frameStart within 3000 clocks");
    end
    lk = locked;
  endtask

  initial begin
    int fs;
    logic [2:0] lkv;
    logic lk;

    tbl[0] = '{4,  100, 10'd0,   10'd0, 1'b0, 12'h000};
    tbl[1] = '{5,  19,  10'd0,   10'd0, 1'b0, 12'h000};
    tbl[2] = '{5,  20,  10'd0,   10'd0, 1'b1, 12'h00A};
    tbl[3] = '{5,  30,  10'd10,  10'd0, 1'b1, 12'hA0A};
    tbl[4] = '{5,  180, 10'd0,   10'd0, 1'b0, 12'h000};
    tbl[5] = '{6,  179, 10'd159, 10'd1, 1'b1, 12'hF1A};
    tbl[6] = '{8,  100, 10'd80,  10'd3, 1'b1, 12'h03A};
    tbl[7] = '{10, 179, 10'd159, 10'd5, 1'b1, 12'hF5A};
    tbl[8] = '{11, 20,  10'd0,   10'd0, 1'b0, 12'h000};
    tbl[9] = '{0,  20,  10'd0,   10'd0, 1'b0, 12'h000};

    // reset state
    repeat (3) @(negedge clock);
    check("rst_pixelX", pixelX, 0);
    check("rst_pixelY", pixelY, 0);
    check("rst_active", active, 0);
    check("rst_rgb", {redOut, greenOut, blueOut}, 0);
    check("rst_frameStart", frameStart, 0);
    check("rst_locked", locked, 0);
    check("rst_errorCount", errorCount, 0);
    res = 1'b1;
    hold(10);

    // three nominal frames: lock comes with the third frameStart
    fs = 0; lkv = '0;
    for (int i = 0; i < 3*HT*VT; i++) begin
      tick();
      if (frameStart) begin
        if (fs < 3) lkv[fs] = locked;
        fs++;
      end
    end
    check("fs_count", fs, 3);
    check("lock_fs1", lkv[0], 0);
    check("lock_fs2", lkv[1], 0);
    check("lock_fs3", lkv[2], 1);
    check("err_nominal", errorCount, 0);

    // coordinate/RGB probes, 3 clocks after the pin sample
    for (int i = 0; i < 10; i++) begin
      run_to(tbl[i].v, tbl[i].h);
      repeat (4) tick();
      check($sformatf("pix_vec%0d", i),
            {pixelX, pixelY, active, redOut, greenOut, blueOut},
            {tbl[i].px, tbl[i].py, tbl[i].act, tbl[i].rgb});
    end
    check("locked_probe", locked, 1);

    // line 3 stretched to 201 clocks
    run_to(3, 0);
    hlen = HT + 1;
    run_to(4, 0);
    repeat (3) tick();
    check("stretch_lock_2clk", locked, 1);
    tick();
    check("stretch_lock_3clk", locked, 0);
    check("stretch_err", errorCount, 1);
    wait_fs(lk);
    check("stretch_relock_fs1", lk, 0);
    wait_fs(lk);
    check("stretch_relock_fs2", lk, 1);

    // hsync stuck high: one timeout, then a bad line when hsync returns
    run_to(6, 0);
    hold(3000);
    check("timeout_err", errorCount, 2);
    check("timeout_locked", locked, 0);
    repeat (4) tick();
    check("timeout_resume_err", errorCount, 3);
    wait_fs(lk);
    check("timeout_fs1", lk, 0);
    wait_fs(lk);
    check("timeout_fs2", lk, 1);
    check("timeout_no_repeat", errorCount, 3);

    // asynchronous reset mid-frame while locked
    run_to(7, 50);
    check("pre_rst_locked", locked, 1);
    res = 1'b0;
    #1;
    check("midrst_outputs",
          {pixelX, pixelY, active, redOut, greenOut, blueOut, frameStart, locked, errorCount}, 0);
    repeat (5) tick();
    res = 1'b1;
    wait_fs(lk);
    check("rst_relock_fs1", lk, 0);
    wait_fs(lk);
    check("rst_relock_fs2", lk, 0);
    wait_fs(lk);
    check("rst_relock_fs3", lk, 1);
    check("rst_relock_err", errorCount, 0);

    // malformed 20-clock lines drive errorCount into saturation
    run_to(3, 0);
    short_lines(100);
    check("sat_err_99", errorCount, 99);
    short_lines(200);
    check("sat_err_255", errorCount, 255);
    short_lines(50);
    check("sat_err_hold", errorCount, 255);
    check("sat_locked", locked, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_receiver.md
# vga_receiver

Sink-side counterpart of the VGA timing generator: consumes a negative-polarity horizontalSync/verticalSync pair plus 4-bit RGB, recovers the pixel coordinate of every sample, checks line and frame lengths against the nominal 640x480@60 timing, and reports lock and error status. It sits on the monitor/capture side of the VGA link. In loopback benches it is driven directly by the generator's outputs to check them.

## Interface
- H_TOTAL, 800: clocks per line
- H_SYNC, 96: hsync low width, in clocks
- H_BACK, 48: back porch, in clocks
- H_ACTIVE, 640: visible pixels per line
- V_TOTAL, 525: lines per frame
- V_SYNC, 2; V_BACK, 33; V_ACTIVE, 480: vertical equivalents, in lines
- LOCK_FRAMES, 2: consecutive good frames required for lock (1..15)

Ports:
- clock  in  1  pixel clock; one clock, all logic on its rising edge
- res  in  1  reset, asynchronous, active-low
- horizontalSync  in  1  active-low hsync
- verticalSync  in  1  active-low vsync
- red, green, blue  in  4 each  pixel data
- pixelX  out  10  column within active area
- pixelY  out  10  row within active area
- active  out  1  high when pixelX/pixelY address a visible pixel
- redOut, greenOut, blueOut  out  4 each  RGB aligned to pixelX/pixelY; 0 when active=0
- frameStart  out  1  one-clock pulse on each detected vsync falling edge
- locked  out  1  timing verified
- errorCount  out  8  saturating count of bad lines, bad frames and timeouts

## Operation
- Both sync inputs pass through a 2-flop synchronizer. The RGB inputs pass through a matching 2-stage delay. Falling edges (hsFall, vsFall) are detected on the synchronized signals.
- hCount (11 bit): 0 on the hsFall cycle, otherwise +1 per clock, saturating at 2047.
- Line check on each hsFall, only once a previous hsFall exists since reset: the line is bad if the previous hCount+1 != H_TOTAL.
- lineCount (10 bit):
  - +1 on hsFall without vsFall.
  - On vsFall, compute measured = lineCount + (hsFall ? 1 : 0). The frame is bad if measured != V_TOTAL.
  - lineCount is then set to 0.
  - Frame check is skipped on the first vsFall after reset (seenVsync flag).
- Timeout: hCount reaching 2047 counts as one error event; it does not repeat until the next hsFall.
- Lock FSM:
  - States: SEARCH, VERIFY, LOCKED.
  - SEARCH -> VERIFY on the first vsFall.
  - In VERIFY, each good frame increments goodFrames (4 bit). At LOCK_FRAMES -> LOCKED.
  - Any error in VERIFY or LOCKED -> VERIFY with goodFrames=0.
- locked=1 only in LOCKED.
- Active window:
  - H_SYNC+H_BACK <= hCount < H_SYNC+H_BACK+H_ACTIVE, and
  - V_SYNC+V_BACK <= lineCount < V_SYNC+V_BACK+V_ACTIVE.
- pixelX = hCount-(H_SYNC+H_BACK) and pixelY = lineCount-(V_SYNC+V_BACK), both truncated to 10 bits. Both are forced to 0 when not active.
- active is independent of locked. Consumers gate on active && locked.
- errorCount: +1 per error event, saturates at 255. Simultaneous bad line and bad frame in one cycle count +2, saturating.

## Timing
- All outputs are registered. Latency from input pins to outputs is exactly 3 clocks (2 sync + 1 output register), identical for sync-derived and RGB outputs.
- frameStart pulses 3 clocks after the vsync falling edge at the pins.
- locked rises in the same cycle frameStart marks the LOCK_FRAMES-th good frame end. It falls 3 clocks after the pin edge that reveals the error.
- Reset (res=0) forces the following immediately, independent of clock:
  - all outputs 0;
  - all counters, synchronizers and seenVsync flags cleared;
  - FSM=SEARCH.
- Reset mid-frame therefore requires LOCK_FRAMES+1 vsync falls to relock.
- hsFall coincident with vsFall: the hsync starts line 0 of the new frame and counts toward the closing frame via the +1 rule.

## Test plan
- Generator-driven nominal stream, LOCK_FRAMES=2, 3 frames -> frameStart pulses 3; locked rises with the 3rd frameStart; errorCount=0.
- Locked stream, RGB input = {x[3:0], y[3:0], 4'hA} -> the first visible pixel gives pixelX=0, pixelY=0, active=1, redOut=0, blueOut=A, 3 clocks after the pin sample. Column 639 has active=1; column 640 has active=0 and RGB out 0.
- Locked, one line stretched to 801 clocks -> locked falls 3 clocks after that line's closing hsync edge; errorCount=1; relock after 2 further good frames.
- hsync held high for 3000 clocks -> exactly one timeout, errorCount +1, locked=0. Normal hsync then resumes without further timeouts.
- res pulsed low mid-frame while locked -> all outputs 0 immediately. After release, locked returns only at the 3rd vsync fall.
- 300 malformed lines -> errorCount saturates at 255 and holds.
